// File: rtl/axi_mem_pkg.sv
// Shared FSM state type and AXI encodings for the memory BIST.
package axi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WDATA,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } bist_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Byte address of a 32-bit beat index.
  function automatic logic [31:0] beat_to_addr(input logic [31:0] beat);
    return beat << 2;
  endfunction

endpackage

// File: rtl/bist_pattern.sv
// Test pattern generator and comparator: expected word = beat index XOR seed.
module bist_pattern #(
  parameter int unsigned G_DATAWIDTH = 32,
  parameter int unsigned G_IDXWIDTH  = 11
) (
  input  logic [G_IDXWIDTH-1:0]  idx,
  input  logic [G_DATAWIDTH-1:0] seed,
  input  logic [G_DATAWIDTH-1:0] data,
  output logic [G_DATAWIDTH-1:0] expected_c,
  output logic                   mismatch_c
);

  // Pattern word for the addressed beat and its comparison against data.
  always_comb begin
    expected_c = G_DATAWIDTH'(idx) ^ seed;
    mismatch_c = (data != expected_c);
  end

endmodule

// File: rtl/axi_mem_bist.sv
// AXI4 memory BIST master: writes an index^seed pattern in INCR bursts,
// reads it back, and reports error count and first failing address.
module axi_mem_bist
  import axi_mem_pkg::*;
#(
  parameter int unsigned G_DATAWIDTH = 32,
  parameter int unsigned G_MEMDEPTH  = 1024,
  parameter int unsigned G_ID_WIDTH  = 1,
  parameter int unsigned G_BURSTLEN  = 16
) (
  input  logic                   s_aclk,
  input  logic                   s_aresetn,
  input  logic                   i_start,
  input  logic [G_DATAWIDTH-1:0] i_seed,
  output logic [G_ID_WIDTH-1:0]  m_axi_awid,
  output logic [31:0]            m_axi_awaddr,
  output logic [7:0]             m_axi_awlen,
  output logic [2:0]             m_axi_awsize,
  output logic [1:0]             m_axi_awburst,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [G_DATAWIDTH-1:0] m_axi_wdata,
  output logic [3:0]             m_axi_wstrb,
  output logic                   m_axi_wlast,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  input  logic [G_ID_WIDTH-1:0]  m_axi_bid,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  output logic [G_ID_WIDTH-1:0]  m_axi_arid,
  output logic [31:0]            m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [G_ID_WIDTH-1:0]  m_axi_rid,
  input  logic [G_DATAWIDTH-1:0] m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rlast,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_pass,
  output logic [15:0]            o_err_cnt,
  output logic [31:0]            o_first_err_addr
);

  localparam int unsigned CW = $clog2(G_MEMDEPTH) + 1;
  localparam int unsigned BW = (G_BURSTLEN > 1) ? $clog2(G_BURSTLEN) : 1;
  localparam logic [CW-1:0] BEAT_END  = CW'(G_MEMDEPTH);
  localparam logic [BW-1:0] BURST_END = BW'(G_BURSTLEN - 1);
  localparam logic [7:0]    AXI_LEN   = 8'(G_BURSTLEN - 1);

  bist_state_t             state;
  logic [CW-1:0]           beat;
  logic [BW-1:0]           bbeat;
  logic [G_DATAWIDTH-1:0]  seed_q;
  logic [31:0]             burst_addr;

  logic [CW-1:0]           beat_inc_c;
  logic [CW-1:0]           pat_idx_c;
  logic [31:0]             beat_addr_c;
  logic [31:0]             next_addr_c;
  logic                    burst_end_c;
  logic [G_DATAWIDTH-1:0]  expected_c;
  logic                    mismatch_c;
  logic                    err_c;
  logic [31:0]             err_addr_c;
  logic                    unused_c;

  // Fixed burst attributes, zeroed while idle.
  assign m_axi_awid    = '0;
  assign m_axi_arid    = '0;
  assign m_axi_awlen   = o_busy ? AXI_LEN : 8'h00;
  assign m_axi_arlen   = o_busy ? AXI_LEN : 8'h00;
  assign m_axi_awsize  = o_busy ? AXI_SIZE_4B : 3'b000;
  assign m_axi_arsize  = o_busy ? AXI_SIZE_4B : 3'b000;
  assign m_axi_awburst = o_busy ? AXI_BURST_INCR : 2'b00;
  assign m_axi_arburst = o_busy ? AXI_BURST_INCR : 2'b00;
  assign m_axi_wstrb   = o_busy ? 4'hF : 4'h0;
  assign unused_c      = ^{m_axi_bid, m_axi_rid};

  // Beat/address arithmetic; during WDATA the pattern looks one beat ahead.
  always_comb begin
    beat_inc_c  = beat + CW'(1);
    pat_idx_c   = (state == WDATA) ? beat_inc_c : beat;
    beat_addr_c = beat_to_addr(32'(beat));
    next_addr_c = beat_to_addr(32'(beat_inc_c));
    burst_end_c = (bbeat == BURST_END);
  end

  bist_pattern #(
    .G_DATAWIDTH (G_DATAWIDTH),
    .G_IDXWIDTH  (CW)
  ) u_pattern (
    .idx        (pat_idx_c),
    .seed       (seed_q),
    .data       (m_axi_rdata),
    .expected_c (expected_c),
    .mismatch_c (mismatch_c)
  );

  // Error detection on write responses and read beats.
  always_comb begin
    err_c      = 1'b0;
    err_addr_c = beat_addr_c;
    if (state == WRESP && m_axi_bvalid && m_axi_bready && m_axi_bresp != AXI_RESP_OKAY) begin
      err_c      = 1'b1;
      err_addr_c = burst_addr;
    end else if (state == RDATA && m_axi_rvalid && m_axi_rready &&
                 (mismatch_c || m_axi_rresp != AXI_RESP_OKAY || m_axi_rlast != burst_end_c)) begin
      err_c = 1'b1;
    end
  end

  // BIST sequencer with registered AXI handshakes and status.
  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      state            <= IDLE;
      beat             <= '0;
      bbeat            <= '0;
      seed_q           <= '0;
      burst_addr       <= '0;
      m_axi_awaddr     <= '0;
      m_axi_awvalid    <= 1'b0;
      m_axi_wdata      <= '0;
      m_axi_wlast      <= 1'b0;
      m_axi_wvalid     <= 1'b0;
      m_axi_bready     <= 1'b0;
      m_axi_araddr     <= '0;
      m_axi_arvalid    <= 1'b0;
      m_axi_rready     <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
      o_err_cnt        <= '0;
      o_first_err_addr <= '0;
    end else begin
      o_done <= 1'b0;
      if (err_c) begin
        if (o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
        if (o_err_cnt == 16'd0)    o_first_err_addr <= err_addr_c;
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            state            <= WADDR;
            o_busy           <= 1'b1;
            seed_q           <= i_seed;
            beat             <= '0;
            bbeat            <= '0;
            burst_addr       <= '0;
            m_axi_awaddr     <= '0;
            m_axi_awvalid    <= 1'b1;
            o_err_cnt        <= '0;
            o_first_err_addr <= '0;
            o_pass           <= 1'b0;
          end
        end
        WADDR: begin
          if (m_axi_awready) begin
            state         <= WDATA;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wvalid  <= 1'b1;
            m_axi_wdata   <= expected_c;
            m_axi_wlast   <= burst_end_c;
          end
        end
        WDATA: begin
          if (m_axi_wready) begin
            beat <= beat_inc_c;
            if (m_axi_wlast) begin
              state        <= WRESP;
              bbeat        <= '0;
              m_axi_wvalid <= 1'b0;
              m_axi_wlast  <= 1'b0;
              m_axi_wdata  <= '0;
              m_axi_bready <= 1'b1;
            end else begin
              bbeat       <= bbeat + BW'(1);
              m_axi_wdata <= expected_c;
              m_axi_wlast <= ((bbeat + BW'(1)) == BURST_END);
            end
          end
        end
        WRESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (beat == BEAT_END) begin
              state         <= RADDR;
              beat          <= '0;
              burst_addr    <= '0;
              m_axi_araddr  <= '0;
              m_axi_arvalid <= 1'b1;
            end else begin
              state         <= WADDR;
              burst_addr    <= beat_addr_c;
              m_axi_awaddr  <= beat_addr_c;
              m_axi_awvalid <= 1'b1;
            end
          end
        end
        RADDR: begin
          if (m_axi_arready) begin
            state         <= RDATA;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_rready  <= 1'b1;
          end
        end
        RDATA: begin
          if (m_axi_rvalid) begin
            beat <= beat_inc_c;
            if (burst_end_c) begin
              bbeat        <= '0;
              m_axi_rready <= 1'b0;
              if (beat_inc_c == BEAT_END) begin
                state  <= DONE;
                o_done <= 1'b1;
                o_pass <= (o_err_cnt == 16'd0) && !err_c;
              end else begin
                state         <= RADDR;
                burst_addr    <= next_addr_c;
                m_axi_araddr  <= next_addr_c;
                m_axi_arvalid <= 1'b1;
              end
            end else begin
              bbeat <= bbeat + BW'(1);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
